// File: rtl/latency_pipe_pkg.sv
// Shared constants and pointer helpers for the latency_pipe delay line.
package latency_pipe_pkg;

  // Ceiling log2, returns 0 for values of 0 or 1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Default depth and the matching width of the latency port.
  localparam int NMAX_DEF = 16;
  localparam int LW = clog2(NMAX_DEF + 1);

  // Circular increment over n slots.
  function automatic int wrap_inc(input int p, input int n);
    return (p >= n - 1) ? 0 : p + 1;
  endfunction

  // (a - b) mod n, valid for 0 <= a < n and 0 <= b <= n.
  function automatic int mod_sub(input int a, input int b, input int n);
    return (a >= b) ? (a - b) : (a + n - b);
  endfunction

endpackage

// File: rtl/latency_pipe_if.sv
// Data/control bundle between a producer and the latency_pipe delay line.
interface latency_pipe_if #(
  parameter int C  = 2,
  parameter int B  = 8,
  parameter int LW = 5
);
  logic            clk_en;
  logic            flush;
  logic [LW-1:0]   lat;
  logic [C*B-1:0]  din;
  logic            din_valid;
  logic [C*B-1:0]  dout;
  logic            dout_valid;
  logic            primed;
  logic            lat_err;

  modport master (
    output clk_en, flush, lat, din, din_valid,
    input  dout, dout_valid, primed, lat_err
  );

  modport slave (
    input  clk_en, flush, lat, din, din_valid,
    output dout, dout_valid, primed, lat_err
  );
endinterface

// File: rtl/latency_pipe_dly_ring_mem.sv
// Slot storage for the delay line: one write port, one combinational read
// port, and a bulk clear of every valid bit that leaves the data untouched.
module dly_ring_mem #(
  parameter int N  = 16,
  parameter int W  = 16,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          wvalid,
  input  logic          clr,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata,
  output logic          rvalid
);

  logic [W-1:0] data_q [N];
  logic [N-1:0] valid_q;

  // Clear runs first so a write in the same cycle lands as the first fresh sample.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) data_q[i] <= '0;
      valid_q <= '0;
    end else begin
      if (clr) valid_q <= '0;
      if (we) begin
        data_q[waddr]  <= wdata;
        valid_q[waddr] <= wvalid;
      end
    end
  end

  assign rdata  = data_q[raddr];
  assign rvalid = valid_q[raddr];

endmodule

// File: rtl/latency_pipe.sv
// Programmable-latency, multi-channel delay line built on a circular slot
// array. Any latency change or flush drops everything in flight.
module latency_pipe #(
  parameter int NMAX    = 16,
  parameter int C       = 2,
  parameter int B       = 8,
  parameter int LAT_DEF = 2
) (
  input logic          clk,
  input logic          rstn,
  latency_pipe_if.slave bus
);
  import latency_pipe_pkg::*;

  localparam int LW = clog2(NMAX + 1);
  localparam int PW = (NMAX > 1) ? clog2(NMAX) : 1;

  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [LW-1:0]  lat_q;
  logic [LW-1:0]  lat_c;
  logic [LW-1:0]  fill;
  logic           lat_over;
  logic           lat_chg;
  logic           inval;
  logic           lat_err_q;
  logic [C*B-1:0] rdata;
  logic           rvalid;
  logic [C*B-1:0] dout_c;
  logic           dout_valid_c;

  assign lat_over = bus.lat > LW'(NMAX);
  assign lat_c    = lat_over ? LW'(NMAX) : bus.lat;
  assign lat_chg  = lat_c != lat_q;
  assign inval    = bus.flush | lat_chg;
  assign rptr     = PW'(mod_sub(int'(wptr), int'(lat_q), NMAX));

  // Latency capture, sticky range error, write pointer and fill count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr      <= '0;
      fill      <= '0;
      lat_q     <= LW'(LAT_DEF);
      lat_err_q <= 1'b0;
    end else begin
      lat_q <= lat_c;
      if (lat_over) lat_err_q <= 1'b1;
      if (bus.clk_en) wptr <= PW'(wrap_inc(int'(wptr), NMAX));
      if (inval) fill <= bus.clk_en ? LW'(1) : '0;
      else if (bus.clk_en && (fill != LW'(NMAX))) fill <= fill + 1'b1;
    end
  end

  dly_ring_mem #(
    .N  (NMAX),
    .W  (C*B),
    .PW (PW)
  ) u_mem (
    .clk    (clk),
    .rstn   (rstn),
    .we     (bus.clk_en),
    .waddr  (wptr),
    .wdata  (bus.din),
    .wvalid (bus.din_valid),
    .clr    (inval),
    .raddr  (rptr),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  // Zero latency bypasses the array; otherwise data is masked by its valid bit.
  always_comb begin
    dout_c       = '0;
    dout_valid_c = 1'b0;
    if (lat_q == '0) begin
      dout_c       = bus.din;
      dout_valid_c = bus.din_valid;
    end else begin
      dout_valid_c = rvalid;
      dout_c       = rvalid ? rdata : '0;
    end
  end

  assign bus.dout       = dout_c;
  assign bus.dout_valid = dout_valid_c;
  assign bus.primed     = fill >= lat_q;
  assign bus.lat_err    = lat_err_q;

endmodule

// File: tb/tb_latency_pipe.sv
// Directed bench for latency_pipe with NMAX=16, C=2, B=8, LAT_DEF=2.
module tb_latency_pipe;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  latency_pipe_if #(.C(2), .B(8), .LW(5)) bus ();

  latency_pipe #(
    .NMAX    (16),
    .C       (2),
    .B       (8),
    .LAT_DEF (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic en, input logic fl, input logic [4:0] l,
                                input logic [15:0] d, input logic v);
    bus.clk_en    = en;
    bus.flush     = fl;
    bus.lat       = l;
    bus.din       = d;
    bus.din_valid = v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dout(input string tag, input logic ev, input logic [15:0] ed);
    check_output({tag, "_valid"}, 16'(bus.dout_valid), 16'(ev));
    check_output({tag, "_data"}, bus.dout, ed);
  endtask

  logic        g_en  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] g_din [8] = '{16'hAAAA, 16'hDEAD, 16'hDEAD, 16'hBBBB,
                            16'hCCCC, 16'hDEAD, 16'hDDDD, 16'hDEAD};
  logic        g_ev  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] g_ed  [8] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                            16'hAAAA, 16'hAAAA, 16'hBBBB};

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of all scenarios.
  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset state.
    rstn = 1'b0;
    apply_stimulus(1'b0, 1'b0, 5'd2, 16'h0, 1'b0);
    tick();
    tick();
    rstn = 1'b1;
    apply_stimulus(1'b0, 1'b0, 5'd2, 16'h0, 1'b0);
    check_dout("reset", 1'b0, 16'h0);
    check_output("reset_primed", 16'(bus.primed), 16'd0);
    check_output("reset_lat_err", 16'(bus.lat_err), 16'd0);

    // Ramp at the default latency of 2.
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus(1'b1, 1'b0, 5'd2, 16'(i), 1'b1);
      if (i >= 3) check_dout("ramp", 1'b1, 16'(i - 2));
      else        check_dout("ramp", 1'b0, 16'h0);
      check_output("ramp_primed", 16'(bus.primed), (i >= 3) ? 16'd1 : 16'd0);
      tick();
    end

    // Full depth with pointer wrap.
    for (int k = 1; k <= 40; k++) begin
      apply_stimulus(1'b1, 1'b0, 5'd16, 16'h1000 + 16'(k), 1'b1);
      if (k >= 17) check_dout("deep", 1'b1, 16'h1000 + 16'(k - 16));
      else if (k >= 2) check_dout("deep", 1'b0, 16'h0);
      if (k >= 2) check_output("deep_primed", 16'(bus.primed), (k >= 17) ? 16'd1 : 16'd0);
      tick();
    end

    // Out-of-range request clamps to 16 and sets the sticky error.
    apply_stimulus(1'b0, 1'b0, 5'd17, 16'hDEAD, 1'b1);
    check_dout("clamp_pre", 1'b1, 16'h1019);
    tick();
    check_output("clamp_lat_err", 16'(bus.lat_err), 16'd1);
    check_dout("clamp_hold", 1'b1, 16'h1019);
    apply_stimulus(1'b0, 1'b0, 5'd4, 16'hDEAD, 1'b1);
    tick();
    check_output("lat4_lat_err", 16'(bus.lat_err), 16'd1);
    check_dout("lat4_inval", 1'b0, 16'h0);
    check_output("lat4_primed", 16'(bus.primed), 16'd0);

    // Gated enable at latency 3.
    for (int c = 0; c < 8; c++) begin
      apply_stimulus(g_en[c], 1'b0, 5'd3, g_din[c], 1'b1);
      check_dout("gated", g_ev[c], g_ed[c]);
      tick();
    end

    // Stream at latency 4, then drop to 2 with samples in flight.
    for (int k = 1; k <= 8; k++) begin
      apply_stimulus(1'b1, 1'b0, 5'd4, 16'h2000 + 16'(k), 1'b1);
      if (k >= 5) check_dout("lat4", 1'b1, 16'h2000 + 16'(k - 4));
      else if (k >= 2) check_dout("lat4", 1'b0, 16'h0);
      tick();
    end
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(1'b1, 1'b0, 5'd2, 16'h3000 + 16'(k), 1'b1);
      if (k == 1)      check_dout("lat2", 1'b1, 16'h2005);
      else if (k >= 3) check_dout("lat2", 1'b1, 16'h3000 + 16'(k - 2));
      else             check_dout("lat2", 1'b0, 16'h0);
      tick();
    end

    // Latency 3, then flush together with a write.
    for (int k = 1; k <= 5; k++) begin
      apply_stimulus(1'b1, 1'b0, 5'd3, 16'h4000 + 16'(k), 1'b1);
      if (k == 1)      check_dout("lat3", 1'b1, 16'h3005);
      else if (k >= 4) check_dout("lat3", 1'b1, 16'h4000 + 16'(k - 3));
      else             check_dout("lat3", 1'b0, 16'h0);
      tick();
    end
    apply_stimulus(1'b1, 1'b1, 5'd3, 16'h5555, 1'b1);
    check_dout("flush_we_pre", 1'b1, 16'h4003);
    tick();
    for (int m = 2; m <= 5; m++) begin
      apply_stimulus(1'b1, 1'b0, 5'd3, 16'h5000 + 16'(m - 1), 1'b1);
      if (m == 4)      check_dout("flush_we", 1'b1, 16'h5555);
      else if (m == 5) check_dout("flush_we", 1'b1, 16'h5001);
      else             check_dout("flush_we", 1'b0, 16'h0);
      tick();
    end

    // Flush with the enable low.
    apply_stimulus(1'b0, 1'b1, 5'd3, 16'hDEAD, 1'b1);
    check_dout("flush_idle_pre", 1'b1, 16'h5002);
    tick();
    for (int n = 1; n <= 4; n++) begin
      apply_stimulus(1'b1, 1'b0, 5'd3, 16'h6000 + 16'(n), 1'b1);
      if (n == 4) check_dout("flush_idle", 1'b1, 16'h6001);
      else        check_dout("flush_idle", 1'b0, 16'h0);
      if (n == 1) check_output("flush_idle_primed", 16'(bus.primed), 16'd0);
      tick();
    end

    // Bypass at latency 0, then latency 1 with both channels.
    apply_stimulus(1'b1, 1'b0, 5'd0, 16'hA53C, 1'b1);
    check_dout("bypass_pre", 1'b1, 16'h6002);
    tick();
    apply_stimulus(1'b1, 1'b0, 5'd0, 16'hA53C, 1'b1);
    check_dout("bypass", 1'b1, 16'hA53C);
    check_output("bypass_primed", 16'(bus.primed), 16'd1);
    apply_stimulus(1'b0, 1'b0, 5'd0, 16'h1234, 1'b0);
    check_dout("bypass_nv", 1'b0, 16'h1234);
    tick();
    apply_stimulus(1'b1, 1'b0, 5'd1, 16'hA53C, 1'b1);
    check_dout("lat1_pre", 1'b1, 16'hA53C);
    tick();
    apply_stimulus(1'b1, 1'b0, 5'd1, 16'h5AC3, 1'b1);
    check_dout("lat1_a", 1'b1, 16'hA53C);
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd1, 16'h7777, 1'b1);
    check_dout("lat1_b", 1'b1, 16'h5AC3);
    check_output("lat1_lat_err", 16'(bus.lat_err), 16'd1);

    // Reset in mid-operation drops everything and clears the error.
    rstn = 1'b0;
    apply_stimulus(1'b1, 1'b0, 5'd2, 16'h8888, 1'b1);
    tick();
    rstn = 1'b1;
    apply_stimulus(1'b0, 1'b0, 5'd2, 16'h0, 1'b0);
    check_dout("rst2", 1'b0, 16'h0);
    check_output("rst2_lat_err", 16'(bus.lat_err), 16'd0);
    check_output("rst2_primed", 16'(bus.primed), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
